// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC and keeps at most one word read in flight
// to instruction memory. It presents the fetched instruction, or a NOP, to the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_Plus4_F,
    output logic        InstrValid_F
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } state_e;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        issue;
    logic        consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC & WORD_MASK;
            pc_q       <= RESET_PC & WORD_MASK;
            pc_plus4_q <= (RESET_PC & WORD_MASK) + 32'd4;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    // A request may only go out once the output slot will be free at the response.
    always_comb begin
        imem_req  = (state_q == ST_REQ) && !PCSrcD && (!valid_q || !StallF);
        imem_addr = fetch_pc_q;
        issue     = imem_req && imem_gnt;
        consume   = valid_q && !StallF && !PCSrcD;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (PCSrcD) begin
            fetch_pc_d = PCBranchD & WORD_MASK;
            instr_d    = 32'h0;
            valid_d    = 1'b0;
            case (state_q)
                ST_WAIT:    state_d = imem_rvalid ? ST_REQ : ST_DISCARD;
                ST_DISCARD: state_d = imem_rvalid ? ST_REQ : ST_DISCARD;
                default:    state_d = ST_REQ;
            endcase
        end else begin
            if (consume) begin
                instr_d = 32'h0;
                valid_d = 1'b0;
            end
            case (state_q)
                ST_REQ: begin
                    if (issue) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr_d    = imem_rdata;
                        valid_d    = 1'b1;
                        pc_d       = fetch_pc_q;
                        pc_plus4_d = fetch_pc_q + 32'd4;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_comb begin
        PC_F         = pc_q;
        PC_Plus4_F   = pc_plus4_q;
        Instr_F      = instr_q;
        InstrValid_F = valid_q;
    end

endmodule
